call_ret_ctrl: RTL

Subroutine call/return sequencer that drives the processor's push/pop return-address stack. It turns decoded CALL and RET requests into stack push/pop transactions with a request/acknowledge handshake, then loads the program counter with the jump target or the popped return address. It sits between instruction decode and the stack. It also tracks stack occupancy so that overflow and underflow can be trapped.

---
 rtl/callret_pkg.sv | 15 +
 rtl/depth_counter.sv | 30 +++
 rtl/call_ret_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/callret_pkg.sv
// Shared types and default sizing for the call/return sequencer.
package callret_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    JUMP,
    FAULT
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

endpackage

// File: rtl/depth_counter.sv
// Up/down occupancy counter for the return-address stack with full/empty flags.
module depth_counter #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/call_ret_ctrl.sv
// CALL/RET sequencer driving a push/pop return-address stack and the PC load strobe.
// Define CALLRET_FAULT_EN to trap overflow/underflow into a sticky FAULT state.
module call_ret_ctrl
  import callret_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     call,
  input  logic                     ret,
  input  logic [DATA_W-1:0]        target,
  input  logic [DATA_W-1:0]        ret_addr,
  output logic                     busy,
  output logic                     pc_load,
  output logic [DATA_W-1:0]        pc_out,
  output logic                     stack_push,
  output logic                     stack_pop,
  output logic [DATA_W-1:0]        stack_din,
  input  logic [DATA_W-1:0]        stack_dout,
  input  logic                     stack_ack,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  logic [DATA_W-1:0] target_q;
  logic              inc, dec, full, empty;
  logic              ovf_trap, unf_trap;

  assign inc = (state == PUSH) && stack_ack;
  assign dec = (state == POP) && stack_ack;

  depth_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .count (depth),
    .full  (full),
    .empty (empty)
  );

`ifdef CALLRET_FAULT_EN
  assign ovf_trap = call && full;
  assign unf_trap = ret && !call && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (state == IDLE) begin
      overflow  <= overflow | ovf_trap;
      underflow <= underflow | unf_trap;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = full ^ empty;
  assign ovf_trap     = 1'b0;
  assign unf_trap     = 1'b0;
  assign overflow     = 1'b0;
  assign underflow    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      pc_load    <= 1'b0;
      pc_out     <= '0;
      stack_push <= 1'b0;
      stack_pop  <= 1'b0;
      stack_din  <= '0;
      target_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // call wins over a simultaneous ret; the dropped ret is re-presented by decode
          if (ovf_trap || unf_trap) begin
            state <= FAULT;
            busy  <= 1'b1;
          end else if (call) begin
            target_q   <= target;
            stack_din  <= ret_addr;
            stack_push <= 1'b1;
            busy       <= 1'b1;
            state      <= PUSH;
          end else if (ret) begin
            stack_pop <= 1'b1;
            busy      <= 1'b1;
            state     <= POP;
          end
        end
        PUSH: begin
          if (stack_ack) begin
            stack_push <= 1'b0;
            pc_out     <= target_q;
            pc_load    <= 1'b1;
            state      <= JUMP;
          end
        end
        POP: begin
          if (stack_ack) begin
            stack_pop <= 1'b0;
            pc_out    <= stack_dout;
            pc_load   <= 1'b1;
            state     <= JUMP;
          end
        end
        JUMP: begin
          pc_load <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
